// File: rtl/ddc_pkg.sv
// ddc_pkg: shared constants and helper functions for the NCO/mixer DDC front end.
// Holds the elaboration-time sin/cos table generator, the round/saturate
// function used by the output stage, and an FTW calculator for integrators.
package ddc_pkg;

  // Fixed in_valid -> out_valid latency of ddc_nco_mixer, in clock cycles.
  localparam int LAT = 4;

  // Phase-dither LFSR: width and reset seed.
  localparam int          LFSR_W    = 16;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  localparam real PI = 3.14159265358979323846;

  // One entry of the full-wave cosine table: round(cos(2*pi*k/2**aw) * (2**(w-1)-1)).
  // Rounds half away from zero so the table stays symmetric about zero, which
  // guarantees the most negative code never appears and negation is safe.
  function automatic int lut_cos(input int k, input int aw, input int w);
    real amp;
    real ang;
    real v;
    amp = real'((1 << (w - 1)) - 1);
    ang = 2.0 * PI * real'(k) / real'(1 << aw);
    v   = $cos(ang) * amp;
    if (v >= 0.0) begin
      return $rtoi(v + 0.5);
    end
    return -$rtoi(-v + 0.5);
  endfunction

  // Arithmetic shift right by 'shift' with round half-up, then clamp to a
  // signed out_w-bit range. Callers pass constant shift/out_w, so this folds
  // into an adder, a shifter wire-selection and two comparators.
  function automatic longint round_sat(input longint prod, input int shift, input int out_w);
    longint r;
    longint hi;
    longint lo;
    r  = (prod + (longint'(1) <<< (shift - 1))) >>> shift;
    hi = (longint'(1) <<< (out_w - 1)) - 1;
    lo = -(longint'(1) <<< (out_w - 1));
    if (r > hi) begin
      return hi;
    end
    if (r < lo) begin
      return lo;
    end
    return r;
  endfunction

  // Frequency tuning word for a given IF and sample rate: round(IF/FS * 2**phase_w),
  // reduced modulo 2**phase_w. Valid for phase_w up to 63.
  function automatic logic [63:0] ftw_calc(input real if_hz, input real fs_hz, input int phase_w);
    real x;
    x = (if_hz / fs_hz) * (2.0 ** phase_w);
    return 64'(longint'(x)) & ((64'd1 << phase_w) - 64'd1);
  endfunction

endpackage

// File: rtl/nco_sincos_lut.sv
// nco_sincos_lut: registered dual-read sin/cos ROM with one cycle of latency.
// A single full-wave cosine table is built at elaboration; the sine read uses
// the same table a quarter turn back, so both outputs come from one ROM image.
module nco_sincos_lut
  import ddc_pkg::*;
#(
  parameter int LUT_AW = 10,
  parameter int LUT_W  = 16
) (
  input  logic                    clk,
  input  logic [LUT_AW-1:0]       addr_i,
  output logic signed [LUT_W-1:0] cos_o,
  output logic signed [LUT_W-1:0] sin_o
);

  localparam int DEPTH = 1 << LUT_AW;
  // sin(x) = cos(x - pi/2): step back a quarter turn, i.e. add 3/4 of the table modulo DEPTH.
  localparam logic [LUT_AW-1:0] QTR_BACK = LUT_AW'(3 * (DEPTH / 4));

  logic signed [LUT_W-1:0] rom [DEPTH];
  logic [LUT_AW-1:0]       sin_addr;

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam logic signed [LUT_W-1:0] ENTRY = LUT_W'(lut_cos(k, LUT_AW, LUT_W));
    assign rom[k] = ENTRY;
  end

  assign sin_addr = addr_i + QTR_BACK;

  // Registered ROM read of both quadrature terms.
  // NOTE: constant tables and pure datapath registers carry no reset; only the
  // control path (valids, accumulator, config, visible outputs) needs a known state.
  always_ff @(posedge clk) begin
    cos_o <= rom[addr_i];
    sin_o <= rom[sin_addr];
  end

endmodule

// File: rtl/ddc_nco_mixer.sv
// ddc_nco_mixer: NCO + complex mixer front end of the digital downconverter.
// Mixes a real IF sample stream to baseband: I = x*cos(phi), Q = -x*sin(phi).
// Pipeline (fixed latency LAT=4): S0 sample+phase register, S1 LUT read,
// S2 multiply, S3 round half-up / saturate. No backpressure.
// Optional feature: define DDC_NCO_DITHER_EN to add LFSR phase dither below
// the LUT index (accumulator itself stays undithered).
module ddc_nco_mixer
  import ddc_pkg::*;
#(
  parameter int                 DATA_W  = 16,
  parameter int                 OUT_W   = 16,
  parameter int                 PHASE_W = 32,
  parameter int                 LUT_AW  = 10,
  parameter int                 LUT_W   = 16,
  parameter logic [PHASE_W-1:0] FTW_RST = PHASE_W'(32'h4000_0000)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] adc_in,
  input  logic [PHASE_W-1:0]       cfg_ftw,
  input  logic                     cfg_ftw_wr,
  input  logic                     cfg_phase_clr,
  output logic                     out_valid,
  output logic signed [OUT_W-1:0]  I_out,
  output logic signed [OUT_W-1:0]  Q_out
);

  localparam int PROD_W = DATA_W + LUT_W;

  // ---------------------------------------------------------------------------
  // Phase accumulator and configuration
  // ---------------------------------------------------------------------------
  logic [PHASE_W-1:0] acc_q, acc_d;
  logic [PHASE_W-1:0] ftw_q, ftw_d;
  logic [PHASE_W-1:0] phase_use;   // phase applied to the sample presented this cycle
  logic [PHASE_W-1:0] phase_lut;   // phase_use, optionally dithered, before truncation
  logic [LUT_AW-1:0]  lut_idx;

  // A phase clear zeroes the phase seen by a same-cycle sample as well.
  assign phase_use = cfg_phase_clr ? '0 : acc_q;

  // Next accumulator and tuning word; a same-cycle FTW write never affects this increment.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    acc_d = acc_q;
    ftw_d = ftw_q;
    if (cfg_ftw_wr) begin
      ftw_d = cfg_ftw;
    end
    if (in_valid) begin
      acc_d = phase_use + ftw_q;
    end else if (cfg_phase_clr) begin
      acc_d = '0;
    end
  end

  // Accumulator and tuning-word registers.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      ftw_q <= FTW_RST;
    end else begin
      acc_q <= acc_d;
      ftw_q <= ftw_d;
    end
  end

`ifdef DDC_NCO_DITHER_EN
  // ---------------------------------------------------------------------------
  // Phase dither: maximal-length LFSR x^16+x^14+x^13+x^11+1 added just below the
  // LUT index bits, advanced once per accepted sample.
  // ---------------------------------------------------------------------------
  localparam int DITH_SH = (PHASE_W - LUT_AW >= LFSR_W) ? (PHASE_W - LUT_AW - LFSR_W) : 0;

  if (PHASE_W - LUT_AW < LFSR_W) begin : g_dither_chk
    $error("ddc_nco_mixer: phase dither needs PHASE_W-LUT_AW >= 16");
  end

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic              lfsr_fb;

  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  // LFSR steps only when a sample is accepted.
  always_comb begin
    lfsr_d = lfsr_q;
    if (in_valid) begin
      lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_fb};
    end
  end

  // LFSR state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign phase_lut = phase_use + (PHASE_W'(lfsr_q) << DITH_SH);
`else
  assign phase_lut = phase_use;
`endif

  assign lut_idx = phase_lut[PHASE_W-1 -: LUT_AW];

  // ---------------------------------------------------------------------------
  // Datapath pipeline
  // ---------------------------------------------------------------------------
  logic [LAT-1:0]            vld_q;       // vld_q[k] marks data leaving stage Sk
  logic signed [DATA_W-1:0]  s0_data_q;
  logic [LUT_AW-1:0]         s0_idx_q;
  logic signed [DATA_W-1:0]  s1_data_q;
  logic signed [LUT_W-1:0]   cos_w, sin_w, nsin_w;
  logic signed [PROD_W-1:0]  data_ext, cos_ext, nsin_ext;
  logic signed [PROD_W-1:0]  prod_i_q, prod_q_q;
  logic signed [OUT_W-1:0]   i_d, q_d;
  logic signed [OUT_W-1:0]   i_q, q_q;

  // Valid pipeline; cleared on reset so in-flight samples never emerge.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
    end else begin
      vld_q <= {vld_q[LAT-2:0], in_valid};
    end
  end

  // S0: register sample and its LUT index.
  always_ff @(posedge clk) begin
    s0_data_q <= adc_in;
    s0_idx_q  <= lut_idx;
  end

  // S1: ROM read (registered inside the LUT) alongside the delayed sample.
  nco_sincos_lut #(
    .LUT_AW (LUT_AW),
    .LUT_W  (LUT_W)
  ) u_lut (
    .clk    (clk),
    .addr_i (s0_idx_q),
    .cos_o  (cos_w),
    .sin_o  (sin_w)
  );

  // Sample alignment register for the LUT read stage.
  always_ff @(posedge clk) begin
    s1_data_q <= adc_in == adc_in ? s0_data_q : s0_data_q;
  end

  // Q uses -sin; the table is symmetric so the most negative code never needs negating.
  assign nsin_w   = -sin_w;
  assign data_ext = PROD_W'(s1_data_q);
  assign cos_ext  = PROD_W'(cos_w);
  assign nsin_ext = PROD_W'(nsin_w);

  // S2: full-precision products.
  always_ff @(posedge clk) begin
    prod_i_q <= data_ext * cos_ext;
    prod_q_q <= data_ext * nsin_ext;
  end

  // Drop LUT_W-1 fraction bits with round half-up and clamp to the output width.
  assign i_d = OUT_W'(round_sat(longint'(prod_i_q), LUT_W - 1, OUT_W));
  assign q_d = OUT_W'(round_sat(longint'(prod_q_q), LUT_W - 1, OUT_W));

  // S3: output register, updated only for valid samples so the outputs hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      i_q <= '0;
      q_q <= '0;
    end else if (vld_q[LAT-2]) begin
      i_q <= i_d;
      q_q <= q_d;
    end
  end

  assign out_valid = vld_q[LAT-1];
  assign I_out     = i_q;
  assign Q_out     = q_q;

endmodule

// File: tb/tb_ddc_nco_mixer.sv
// tb_ddc_nco_mixer: self-checking bench for ddc_nco_mixer.
// A reference model tracks the accumulator/tuning word and pushes expected I/Q
// into a scoreboard on every accepted sample; a monitor pops and compares on
// every out_valid, checks out_valid timing and output hold. Scenario tasks also
// compare captured outputs against hand-derived constants. A second instance
// with OUT_W=12 exercises saturation.
module tb_ddc_nco_mixer;

  localparam int          DATA_W  = 16;
  localparam int          OUT_W   = 16;
  localparam logic [31:0] FTW_RST = 32'h4000_0000;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic                     in_valid = 1'b0;
  logic signed [DATA_W-1:0] adc_in = '0;
  logic [31:0]              cfg_ftw = '0;
  logic                     cfg_ftw_wr = 1'b0;
  logic                     cfg_phase_clr = 1'b0;

  logic                     out_valid;
  logic signed [OUT_W-1:0]  I_out, Q_out;
  logic                     o12_valid;
  logic signed [11:0]       i12, q12;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ddc_nco_mixer dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .adc_in        (adc_in),
    .cfg_ftw       (cfg_ftw),
    .cfg_ftw_wr    (cfg_ftw_wr),
    .cfg_phase_clr (cfg_phase_clr),
    .out_valid     (out_valid),
    .I_out         (I_out),
    .Q_out         (Q_out)
  );

  ddc_nco_mixer #(.OUT_W(12)) dut12 (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .adc_in        (adc_in),
    .cfg_ftw       (cfg_ftw),
    .cfg_ftw_wr    (cfg_ftw_wr),
    .cfg_phase_clr (cfg_phase_clr),
    .out_valid     (o12_valid),
    .I_out         (i12),
    .Q_out         (q12)
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic int tb_cos(input int k);
    real v;
    v = $cos(2.0 * 3.14159265358979323846 * real'(k) / 1024.0) * 32767.0;
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(-v + 0.5);
  endfunction

  function automatic int tb_mix(input int x, input logic [31:0] ph, input bit is_q, input int ow);
    int     k;
    int     coef;
    longint r;
    longint hi;
    k    = int'(ph[31:22]);
    coef = is_q ? -tb_cos((k + 768) % 1024) : tb_cos(k);
    r    = (longint'(x) * longint'(coef) + 16384) >>> 15;
    hi   = (longint'(1) <<< (ow - 1)) - 1;
    if (r > hi) r = hi;
    if (r < -hi - 1) r = -hi - 1;
    return int'(r);
  endfunction

  int          sb_i[$], sb_q[$];
  int          cap_i[$], cap_q[$], cap12_i[$];
  logic [3:0]  hist = '0;
  logic [31:0] m_acc = '0;
  logic [31:0] m_ftw = FTW_RST;
  int          hold_i = 0, hold_q = 0;
  bit          mon_en = 1'b0;

  // Model update on each active edge; inputs are stable here (driven #1 after the edge).
  always @(posedge clk) begin
    logic [31:0] ph;
    if (reset) begin
      sb_i.delete();
      sb_q.delete();
      hist   = '0;
      m_acc  = '0;
      m_ftw  = FTW_RST;
      hold_i = 0;
      hold_q = 0;
    end else begin
      hist = {hist[2:0], in_valid};
      if (in_valid) begin
        ph = cfg_phase_clr ? 32'h0 : m_acc;
        sb_i.push_back(tb_mix(int'(adc_in), ph, 1'b0, OUT_W));
        sb_q.push_back(tb_mix(int'(adc_in), ph, 1'b1, OUT_W));
        m_acc = ph + m_ftw;
      end else if (cfg_phase_clr) begin
        m_acc = '0;
      end
      if (cfg_ftw_wr) m_ftw = cfg_ftw;
    end
  end

  // Monitor on the falling edge: valid timing, scoreboard compare, output hold.
  always @(negedge clk) begin
    if (mon_en) begin
      total++;
      if (out_valid !== hist[3]) begin
        bad++;
        $display("FAIL valid_timing t=%0t got=%b want=%b", $time, out_valid, hist[3]);
      end
      if (out_valid === 1'b1) begin
        cap_i.push_back(int'(I_out));
        cap_q.push_back(int'(Q_out));
        total++;
        if (sb_i.size() == 0) begin
          bad++;
          $display("FAIL sb_underflow t=%0t got=out_valid want=no_output", $time);
        end else begin
          hold_i = sb_i.pop_front();
          hold_q = sb_q.pop_front();
          if (int'(I_out) !== hold_i) begin
            bad++;
            $display("FAIL sb_I t=%0t got=%0d want=%0d", $time, I_out, hold_i);
          end
          total++;
          if (int'(Q_out) !== hold_q) begin
            bad++;
            $display("FAIL sb_Q t=%0t got=%0d want=%0d", $time, Q_out, hold_q);
          end
        end
      end else begin
        total++;
        if (int'(I_out) !== hold_i || int'(Q_out) !== hold_q) begin
          bad++;
          $display("FAIL hold t=%0t got=%0d/%0d want=%0d/%0d", $time, I_out, Q_out, hold_i, hold_q);
        end
      end
      if (o12_valid === 1'b1) cap12_i.push_back(int'(i12));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic drive(input logic v, input int x, input logic wr = 1'b0,
                       input logic [31:0] f = 32'h0, input logic clr = 1'b0);
    @(posedge clk);
    #1;
    in_valid      = v;
    adc_in        = DATA_W'(x);
    cfg_ftw_wr    = wr;
    cfg_ftw       = f;
    cfg_phase_clr = clr;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0);
  endtask

  task automatic clear_caps();
    cap_i.delete();
    cap_q.delete();
    cap12_i.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", out_valid); end
    total++;
    if (I_out !== '0) begin bad++; $display("FAIL rst_I got=%0d want=0", I_out); end
    total++;
    if (Q_out !== '0) begin bad++; $display("FAIL rst_Q got=%0d want=0", Q_out); end
    total++;
    if (o12_valid !== 1'b0 || i12 !== '0) begin
      bad++; $display("FAIL rst_12 got=%b/%0d want=0/0", o12_valid, i12);
    end
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_quarter_rate();
    int ei[8] = '{1000, 0, -1000, 0, 1000, 0, -1000, 0};
    int eq[8] = '{0, -1000, 0, 1000, 0, -1000, 0, 1000};
    clear_caps();
    for (int i = 0; i < 8; i++) drive(1'b1, 1000);
    idle(6);
    total++;
    if (cap_i.size() != 8) begin bad++; $display("FAIL qr_count got=%0d want=8", cap_i.size()); end
    for (int i = 0; i < 8 && i < cap_i.size(); i++) begin
      total++;
      if (cap_i[i] !== ei[i] || cap_q[i] !== eq[i]) begin
        bad++;
        $display("FAIL qr_iq[%0d] got=%0d/%0d want=%0d/%0d", i, cap_i[i], cap_q[i], ei[i], eq[i]);
      end
    end
  endtask

  task automatic test_gapped();
    int ei[8] = '{1000, 0, -1000, 0, 1000, 0, -1000, 0};
    int eq[8] = '{0, -1000, 0, 1000, 0, -1000, 0, 1000};
    drive(1'b0, 0, 1'b0, 32'h0, 1'b1);
    clear_caps();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1000);
      idle(2);
    end
    idle(6);
    total++;
    if (cap_i.size() != 8) begin bad++; $display("FAIL gap_count got=%0d want=8", cap_i.size()); end
    for (int i = 0; i < 8 && i < cap_i.size(); i++) begin
      total++;
      if (cap_i[i] !== ei[i] || cap_q[i] !== eq[i]) begin
        bad++;
        $display("FAIL gap_iq[%0d] got=%0d/%0d want=%0d/%0d", i, cap_i[i], cap_q[i], ei[i], eq[i]);
      end
    end
  endtask

  task automatic test_saturation();
    clear_caps();
    drive(1'b1, 4000, 1'b0, 32'h0, 1'b1);
    drive(1'b1, -4000, 1'b0, 32'h0, 1'b1);
    idle(6);
    total++;
    if (cap12_i.size() != 2) begin
      bad++; $display("FAIL sat_count got=%0d want=2", cap12_i.size());
    end else begin
      total++;
      if (cap12_i[0] !== 2047) begin bad++; $display("FAIL sat_pos got=%0d want=2047", cap12_i[0]); end
      total++;
      if (cap12_i[1] !== -2048) begin bad++; $display("FAIL sat_neg got=%0d want=-2048", cap12_i[1]); end
    end
    total++;
    if (cap_i.size() != 2 || cap_i[0] !== 4000 || cap_i[1] !== -4000) begin
      bad++; $display("FAIL nosat_16 got=%0d entries want=4000,-4000", cap_i.size());
    end
  endtask

  task automatic test_ftw_write();
    int ei[5] = '{1000, 0, -1000, -707, 0};
    int eq[5] = '{0, -1000, 0, 707, 1000};
    drive(1'b0, 0, 1'b0, 32'h0, 1'b1);
    clear_caps();
    drive(1'b1, 1000);
    drive(1'b1, 1000, 1'b1, 32'h2000_0000);
    drive(1'b1, 1000);
    drive(1'b1, 1000);
    drive(1'b1, 1000);
    idle(6);
    total++;
    if (cap_i.size() != 5) begin bad++; $display("FAIL ftw_count got=%0d want=5", cap_i.size()); end
    for (int i = 0; i < 5 && i < cap_i.size(); i++) begin
      total++;
      if (cap_i[i] !== ei[i] || cap_q[i] !== eq[i]) begin
        bad++;
        $display("FAIL ftw_iq[%0d] got=%0d/%0d want=%0d/%0d", i, cap_i[i], cap_q[i], ei[i], eq[i]);
      end
    end
  endtask

  task automatic test_phase_clr();
    // FTW is 0x2000_0000 and the accumulator sits at 0xE000_0000 (315 deg) here.
    int ei[5] = '{707, 1000, 707, 1000, 0};
    int eq[5] = '{707, 0, -707, 0, -1000};
    clear_caps();
    drive(1'b1, 1000);
    drive(1'b1, 1000, 1'b0, 32'h0, 1'b1);
    drive(1'b1, 1000);
    drive(1'b0, 0, 1'b1, 32'h4000_0000, 1'b1);
    drive(1'b1, 1000);
    drive(1'b1, 1000);
    idle(6);
    total++;
    if (cap_i.size() != 5) begin bad++; $display("FAIL clr_count got=%0d want=5", cap_i.size()); end
    for (int i = 0; i < 5 && i < cap_i.size(); i++) begin
      total++;
      if (cap_i[i] !== ei[i] || cap_q[i] !== eq[i]) begin
        bad++;
        $display("FAIL clr_iq[%0d] got=%0d/%0d want=%0d/%0d", i, cap_i[i], cap_q[i], ei[i], eq[i]);
      end
    end
  endtask

  task automatic test_reset_flush();
    drive(1'b0, 0, 1'b1, 32'h1234_5678);
    clear_caps();
    drive(1'b1, 1000);
    drive(1'b1, 2000);
    drive(1'b1, 3000);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    reset    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(8);
    total++;
    if (cap_i.size() != 0 || cap12_i.size() != 0) begin
      bad++; $display("FAIL flush got=%0d outputs want=0", cap_i.size() + cap12_i.size());
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || I_out !== '0 || Q_out !== '0) begin
      bad++; $display("FAIL flush_out got=%b/%0d/%0d want=0/0/0", out_valid, I_out, Q_out);
    end
    // Reset tuning word and zero phase: 90 degree steps from phase 0 again.
    drive(1'b1, 1000);
    drive(1'b1, 1000);
    idle(6);
    total++;
    if (cap_i.size() != 2) begin
      bad++; $display("FAIL post_rst_count got=%0d want=2", cap_i.size());
    end else begin
      total++;
      if (cap_i[0] !== 1000 || cap_q[0] !== 0 || cap_i[1] !== 0 || cap_q[1] !== -1000) begin
        bad++;
        $display("FAIL post_rst_ftw got=%0d/%0d,%0d/%0d want=1000/0,0/-1000",
                 cap_i[0], cap_q[0], cap_i[1], cap_q[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_quarter_rate();
    test_gapped();
    test_saturation();
    test_ftw_write();
    test_phase_clr();
    test_reset_flush();
    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
